nibble_accumulator_ctrl: RTL and testbench

- Sequencing stage wrapped around the team's 4-bit combinational adder (operands A/B, sum S, carry-out C, no carry-in).
- Feeds the adder the running 4-bit accumulator plus one incoming nibble per accepted transfer, and registers the adder's sum back into the accumulator.
- Counts carry-outs into an upper counter, so a stream of len nibbles is summed into a (CNT_W+4)-bit result.
- Valid/ready on input and output; start/busy control.

---
 rtl/nibble_accumulator_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_accumulator_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_accumulator_ctrl.sv
// nibble_accumulator_ctrl
// Sums a stream of len nibbles through an external 4-bit adder. The low
// nibble lives in acc and is fed back on adder A. Every adder carry-out
// bumps the upper counter hi, so the result is {hi, acc}. If the total
// overflows CNT_W+4 bits, the result pins to all-ones and sat is raised.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; the last result and sat stay visible
// ACCUM | accepting nibbles until remaining reaches zero
// DONE  | result presented on sum_out until out_ready is seen
module nibble_accumulator_ctrl #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    input  logic [3:0]         in_data,
    output logic               in_ready,
    output logic [3:0]         add_a,
    output logic [3:0]         add_b,
    input  logic [3:0]         add_s,
    input  logic               add_c,
    output logic [CNT_W+3:0]   sum_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sat,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HI_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         acc;
    logic [3:0]         acc_nxt;
    logic [CNT_W-1:0]   hi;
    logic [CNT_W-1:0]   hi_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   remaining_nxt;
    logic               sat_q;
    logic               sat_nxt;
    logic               accept;
    logic               start_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        start_ok  = 1'b0;
        case (state)
            IDLE: begin
                start_ok = start;
                if (start) begin
                    // A zero-length request goes straight to DONE with result 0.
                    state_nxt = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (in_valid && (remaining == LEN_ONE)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                // A start in this cycle is dropped on purpose, even during the handshake.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath next values: clear on start, fold in the adder result on each accept.
    always_comb begin
        acc_nxt       = acc;
        hi_nxt        = hi;
        remaining_nxt = remaining;
        sat_nxt       = sat_q;
        if (start_ok) begin
            acc_nxt       = 4'h0;
            hi_nxt        = '0;
            sat_nxt       = 1'b0;
            remaining_nxt = len;
        end else if (accept) begin
            acc_nxt       = add_s;
            remaining_nxt = remaining - LEN_ONE;
            if (add_c) begin
                if (hi != HI_MAX) begin
                    hi_nxt = hi + CNT_W'(1);
                end else begin
                    sat_nxt = 1'b1;
                end
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 4'h0;
            hi        <= '0;
            remaining <= '0;
            sat_q     <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            hi        <= hi_nxt;
            remaining <= remaining_nxt;
            sat_q     <= sat_nxt;
        end
    end

    // Adder drive: B is gated to zero unless a nibble is actually being accepted.
    // This also keeps an X on in_data from reaching the adder.
    always_comb begin
        add_a = acc;
        add_b = accept ? in_data : 4'h0;
    end

    // Result view: saturated results read as all-ones.
    always_comb begin
        sum_out = sat_q ? '1 : {hi, acc};
        sat     = sat_q;
    end

endmodule

// File: tb/tb_nibble_accumulator_ctrl.sv
// Bench for nibble_accumulator_ctrl. The external 4-bit adder is modelled
// with a continuous assign. Expected results come from the plain integer
// total of the nibbles, saturated to the result width.
module tb_nibble_accumulator_ctrl;

    localparam int LEN_W = 8;
    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << (CNT_W + 4)) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LEN_W-1:0]   len;
    logic               in_valid;
    logic [3:0]         in_data;
    logic               in_ready;
    logic [3:0]         add_a;
    logic [3:0]         add_b;
    logic [3:0]         add_s;
    logic               add_c;
    logic [CNT_W+3:0]   sum_out;
    logic               out_valid;
    logic               out_ready;
    logic               sat;
    logic               busy;

    int checks = 0;
    int errors = 0;
    logic [3:0] stim[$];

    nibble_accumulator_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_c     (add_c),
        .sum_out   (sum_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .busy      (busy)
    );

    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat_total(input int t);
        return (t > MAXV) ? MAXV : t;
    endfunction

    task automatic fill_const(input int n, input int v);
        stim = {};
        for (int i = 0; i < n; i++) stim.push_back(4'(v));
    endtask

    task automatic fill_rand(input int n);
        stim = {};
        for (int i = 0; i < n; i++) stim.push_back(4'($urandom_range(0, 15)));
    endtask

    // One full transfer using stim as the data; optional input gaps,
    // output back-pressure, ignored start pulses, and start during handshake.
    task automatic run_transfer(input string tag, input int gap_max, input int bp,
                                input bit poke_start, input bit start_at_hs);
        int total;
        int expv;
        int l;
        int g;
        total = 0;
        l = stim.size();
        start = 1'b1;
        len = LEN_W'(l);
        tick();
        start = 1'b0;
        for (int i = 0; i < l; i++) begin
            g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                in_data = 4'bxxxx;
                start = poke_start;
                len = LEN_W'(7);
                #1;
                checks++;
                if (add_b !== 4'h0 || in_ready !== 1'b1)
                    $display("FAIL %s gap: add_b=%h in_ready=%b, want 0/1", tag, add_b, in_ready);
                if (add_b !== 4'h0 || in_ready !== 1'b1) errors++;
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data = stim[i];
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s accept[%0d]: in_ready=%b out_valid=%b busy=%b, want 1/0/1",
                         tag, i, in_ready, out_valid, busy);
            end
            checks++;
            if (add_a !== 4'(total) || add_b !== stim[i]) begin
                errors++;
                $display("FAIL %s adder[%0d]: add_a=%h add_b=%h, want %h/%h",
                         tag, i, add_a, add_b, 4'(total), stim[i]);
            end
            total += int'(stim[i]);
            tick();
            in_valid = 1'b0;
            in_data = 4'h0;
        end
        expv = sat_total(total);
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: out_valid=%b busy=%b in_ready=%b, want 1/1/0",
                     tag, out_valid, busy, in_ready);
        end
        checks++;
        if (sum_out !== (CNT_W+4)'(expv) || sat !== (total > MAXV)) begin
            errors++;
            $display("FAIL %s result: sum_out=%h sat=%b, want %h/%b",
                     tag, sum_out, sat, (CNT_W+4)'(expv), (total > MAXV));
        end
        for (int k = 0; k < bp; k++) begin
            out_ready = 1'b0;
            start = poke_start;
            len = LEN_W'(3);
            tick();
            start = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || sum_out !== (CNT_W+4)'(expv) || sat !== (total > MAXV)) begin
                errors++;
                $display("FAIL %s hold[%0d]: out_valid=%b sum_out=%h sat=%b, want 1/%h/%b",
                         tag, k, out_valid, sum_out, sat, (CNT_W+4)'(expv), (total > MAXV));
            end
        end
        out_ready = 1'b1;
        start = start_at_hs;
        len = LEN_W'(3);
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: out_valid=%b busy=%b in_ready=%b, want 0/0/0",
                     tag, out_valid, busy, in_ready);
        end
        checks++;
        if (sum_out !== (CNT_W+4)'(expv) || sat !== (total > MAXV)) begin
            errors++;
            $display("FAIL %s kept: sum_out=%h sat=%b, want %h/%b",
                     tag, sum_out, sat, (CNT_W+4)'(expv), (total > MAXV));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum_out !== '0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum_out=%h sat=%b, want all 0",
                     in_ready, out_valid, busy, sum_out, sat);
        end
    endtask

    task automatic test_basic();
        stim = {4'h5, 4'h6, 4'h7};
        run_transfer("basic", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_len_zero();
        start = 1'b1;
        len = '0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0_idle: in_ready=%b busy=%b, want 0/0", in_ready, busy);
        end
        start = 1'b0;
        stim = {};
        run_transfer("len0", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps_backpressure();
        fill_const(4, 15);
        run_transfer("gaps", 2, 5, 1'b1, 1'b0);
    endtask

    task automatic test_saturation();
        fill_const(20, 15);
        run_transfer("sat", 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len = LEN_W'(5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 4'hE;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
            sum_out !== '0 || sat !== 1'b0 || add_a !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b sum_out=%h sat=%b add_a=%h, want all 0",
                     in_ready, out_valid, busy, sum_out, sat, add_a);
        end
        stim = {4'h9};
        run_transfer("after_rst", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        stim = {4'h1, 4'h2};
        run_transfer("b2b", 0, 0, 1'b0, 1'b1);
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lost_start: busy=%b in_ready=%b, want 0/0", busy, in_ready);
        end
        stim = {4'hF, 4'h1, 4'h0};
        run_transfer("b2b_next", 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            if (r % 4 == 3) fill_const(int'($urandom_range(17, 30)), 15);
            else fill_rand(int'($urandom_range(0, 30)));
            run_transfer($sformatf("rand%0d", r), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 4)), r[0], r[1]);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_data = 4'h0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_len_zero();
        test_gaps_backpressure();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
